// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter family.
// Provides the decade width, decade limits, the sanitize result payload and
// the sanitize helper that clamps an out-of-range decade to 9 and flags it.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

    // Sanitized decade plus a flag saying the raw value was not valid BCD.
    typedef struct packed {
        logic             bad;
        logic [BCD_W-1:0] val;
    } bcd_san_t;

    function automatic bcd_san_t sanitize(input logic [BCD_W-1:0] d);
        bcd_san_t r;
        r.bad = (d > BCD_MAX);
        r.val = r.bad ? BCD_MAX : d;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD decade of the down counter.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   load        parallel load of d (wins over borrow_in)
//   d           decade value to load (already sanitized)
//   borrow_in   decrement request from the decade below
//   q           registered decade value
//   borrow_out  borrow passed upward: borrow_in while this decade is 0
module bcd_digit_down
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [BCD_W-1:0] d,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] q,
    output logic             borrow_out
);

    // Decade register: load, else decrement with 0 -> 9 wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= BCD_ZERO;
        end else if (load) begin
            q <= d;
        end else if (borrow_in) begin
            q <= (q == BCD_ZERO) ? BCD_MAX : q - BCD_W'(1);
        end
    end

    assign borrow_out = borrow_in & (q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_count.sv
// Loadable multi-decade BCD down counter with terminal-count pulse.
// Optional feature macro: BCD_DOWN_AUTORELOAD_EN (reload the stored preset
// on an enabled cycle at zero, turning the counter into a periodic divider).
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   load, din   preset strobe and packed BCD preset (decade 0 in din[3:0])
//   en          count enable, one decrement per clock
//   q           current count, packed BCD
//   zero        q == 0, decoded directly from q
//   tc          one-cycle pulse on the edge q reaches 0 by counting
//   busy        countdown in progress
//   bad_bcd     one-cycle flag after a load that had a decade above 9
module bcd_down_count
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] din,
    input  logic                    en,
    output logic [BCD_W*DIGITS-1:0] q,
    output logic                    zero,
    output logic                    tc,
    output logic                    busy,
    output logic                    bad_bcd
);

    localparam int unsigned CW = BCD_W * DIGITS;

    logic [CW-1:0]     din_s;
    logic              bad_any;
    bcd_san_t          san;
    logic [CW-1:0]     preset;
    logic [CW-1:0]     dig_d;
    logic              dig_load;
    logic              cnt_en;
    logic              reload;
    logic              q_one;
    logic [DIGITS:0]   borrow;

    // Clamp each incoming decade to 9 and collect the invalid-BCD flag.
    always_comb begin
        din_s   = '0;
        bad_any = 1'b0;
        san     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            san                          = sanitize(din[i*BCD_W +: BCD_W]);
            din_s[i*BCD_W +: BCD_W]      = san.val;
            bad_any                      = bad_any | san.bad;
        end
    end

    assign zero   = (q == '0);
    // BCD 1 has the same encoding as binary 1.
    assign q_one  = (q == CW'(1));
    assign cnt_en = en & ~load & ~zero;

`ifdef BCD_DOWN_AUTORELOAD_EN
    assign reload = en & ~load & zero & (preset != '0);
`else
    assign reload = 1'b0;
`endif

    // External load takes the sanitized input; autoreload takes the preset.
    assign dig_load = load | reload;
    assign dig_d    = load ? din_s : preset;

    assign borrow[0] = cnt_en;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_down u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (dig_load),
            .d          (dig_d[g*BCD_W +: BCD_W]),
            .borrow_in  (borrow[g]),
            .q          (q[g*BCD_W +: BCD_W]),
            .borrow_out (borrow[g+1])
        );
    end

    // Counting is gated on q != 0, so no borrow can leave the top decade.
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n) !borrow[DIGITS]);

    // Preset, terminal-count, busy and bad-BCD status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            preset  <= '0;
            tc      <= 1'b0;
            busy    <= 1'b0;
            bad_bcd <= 1'b0;
        end else begin
            tc      <= cnt_en & q_one;
            bad_bcd <= load & bad_any;
            if (load) begin
                preset <= din_s;
                busy   <= (din_s != '0);
            end else if (reload) begin
                busy   <= 1'b1;
            end else if (cnt_en & q_one) begin
                busy   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_down_count.sv
// Self-checking bench for bcd_down_count (DIGITS = 2).
// Expected outputs come from a decimal reference model, are queued when the
// stimulus is driven and popped for comparison one step after the edge.
module tb_bcd_down_count;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned CW     = 4 * DIGITS;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [CW-1:0] din;
    logic          en;
    logic [CW-1:0] q;
    logic          zero;
    logic          tc;
    logic          busy;
    logic          bad_bcd;

    typedef struct packed {
        logic [CW-1:0] q;
        logic          zero;
        logic          tc;
        logic          busy;
        logic          bad;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state (decimal count, not BCD)
    int   m_q;
    int   m_pre;
    logic m_tc;
    logic m_busy;
    logic m_bad;

    bcd_down_count #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .din     (din),
        .en      (en),
        .q       (q),
        .zero    (zero),
        .tc      (tc),
        .busy    (busy),
        .bad_bcd (bad_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int bcd_to_int(input logic [CW-1:0] v, output logic bad);
        int r = 0;
        int w = 1;
        logic [3:0] nib;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = v[i*4 +: 4];
            if (nib > 4'd9) begin
                bad = 1'b1;
                nib = 4'd9;
            end
            r += int'(nib) * w;
            w *= 10;
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] int_to_bcd(input int v);
        logic [CW-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Advance the reference model by one clock edge.
    task automatic model_step(input logic r, input logic ld, input logic [CW-1:0] d, input logic e);
        logic b;
        if (!r) begin
            m_q = 0; m_pre = 0; m_tc = 0; m_busy = 0; m_bad = 0;
        end else if (ld) begin
            m_q    = bcd_to_int(d, b);
            m_pre  = m_q;
            m_busy = (m_q != 0);
            m_tc   = 0;
            m_bad  = b;
        end else if (e && m_q != 0) begin
            m_q  = m_q - 1;
            m_tc = (m_q == 0);
            if (m_tc) m_busy = 0;
            m_bad = 0;
        end else begin
            m_tc  = 0;
            m_bad = 0;
`ifdef BCD_DOWN_AUTORELOAD_EN
            if (e && m_q == 0 && m_pre != 0) begin
                m_q    = m_pre;
                m_busy = 1;
            end
`endif
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic step(input logic r, input logic ld, input logic [CW-1:0] d, input logic e);
        exp_t x;
        @(negedge clk);
        rst_n = r; load = ld; din = d; en = e;
        model_step(r, ld, d, e);
        x.q    = int_to_bcd(m_q);
        x.zero = (m_q == 0);
        x.tc   = m_tc;
        x.busy = m_busy;
        x.bad  = m_bad;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            x = exp_q.pop_front();
            check("q",       32'(q),       32'(x.q));
            check("zero",    32'(zero),    32'(x.zero));
            check("tc",      32'(tc),      32'(x.tc));
            check("busy",    32'(busy),    32'(x.busy));
            check("bad_bcd", 32'(bad_bcd), 32'(x.bad));
        end
    endtask

    initial begin
        int tc_edge;
        int tc_count;
        rst_n = 1'b0; load = 1'b0; din = '0; en = 1'b0;

        // Reset overrides a simultaneous load
        step(1'b0, 1'b1, 8'h42, 1'b0);
        step(1'b0, 1'b1, 8'h42, 1'b0);
        check("reset_q", 32'(q), 32'h0);

        // Full countdown from 19; tc only on the 19th edge after load
        step(1'b1, 1'b1, 8'h19, 1'b0);
        tc_edge = 0; tc_count = 0;
        for (int i = 1; i <= 22; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            if (tc) begin
                tc_count++;
                if (tc_edge == 0) tc_edge = i;
            end
        end
        check("tc_edge", 32'(tc_edge), 32'd19);

        // Borrow across the decade boundary
        step(1'b1, 1'b1, 8'h10, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("borrow_09", 32'(q), 32'h09);

        // Clamp of an invalid decade
        step(1'b1, 1'b1, 8'h3A, 1'b0);
        check("clamp_39", 32'(q), 32'h39);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Load wins over en; en low freezes the count
        step(1'b1, 1'b1, 8'h05, 1'b1);
        check("load_prio", 32'(q), 32'h05);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        check("freeze", 32'(q), 32'h03);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Reset mid-count at 07: no tc, no resumption
        step(1'b1, 1'b1, 8'h09, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Short preset with en held (periodic when autoreload is built in)
        step(1'b1, 1'b1, 8'h03, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Load in the tc cycle restarts the count
        step(1'b1, 1'b1, 8'h01, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h12, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Zero preset: busy stays low, count holds
        step(1'b1, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 29) != 0),
                 ($urandom_range(0, 7) == 0),
                 CW'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_down_count.md
# bcd_down_count

Synchronous, loadable, multi-digit BCD down counter. It is the countdown counterpart to the team's synchronous BCD up counters and serves as the count-to-zero timer in the counter family. It loads a BCD preset, decrements by one per enabled clock with decade borrow, and raises a one-cycle terminal-count pulse when the value reaches zero.

## Interface
Parameters:
- DIGITS, default 2: number of BCD decades; count width is 4*DIGITS bits.

Ports:
- clk  in  1  rising-edge clock; the single clock domain.
- rst_n  in  1  reset, synchronous and active-low.
- load  in  1  preset strobe; takes priority over en.
- din  in  4*DIGITS  preset value, packed BCD, least-significant decade in din[3:0].
- en  in  1  count enable; one decrement per clock while high.
- q  out  4*DIGITS  current count, packed BCD.
- zero  out  1  high whenever q equals 0; decoded from the q register.
- tc  out  1  terminal-count pulse, registered.
- busy  out  1  high while q is nonzero and a countdown is in progress; registered.
- bad_bcd  out  1  registered; high for one cycle after a load in which any din decade was greater than 9.

## Operation
- Reset (rst_n low at a clock edge): q=0, tc=0, busy=0, bad_bcd=0, and the stored preset is 0. zero therefore reads 1.
- Each decade of din is sanitized on load: a decade value from 10 to 15 loads as 9, and bad_bcd is set for that cycle.
- A load at a clock edge sets q to the sanitized din and stores the same value as the preset. It also sets busy to (sanitized din != 0) and clears tc. A simultaneous en is ignored.
- Enabled count (en high, load low, q != 0):
  - Decade 0 decrements.
  - Any decade that is 0 and receives a borrow wraps to 9 and passes the borrow upward.
  - A decade receives a borrow only when every lower decade is 0.
- Terminal count: on the edge where q goes from a nonzero value to 0 through counting, tc=1 for exactly one cycle and busy=0.
- Enabled while q == 0 (autoreload not compiled in): q holds at 0, tc stays 0, busy stays 0.
- en low: q holds and tc=0.
- Arithmetic is decade-wise BCD only. No binary intermediate is used, and q never contains a decade greater than 9.

## Timing
- Load-to-q latency is 1 clock. q reflects din on the edge where load is sampled.
- Count latency is 1 clock per decrement. From preset N with en held high, q reaches 0, and tc pulses, N edges after the load edge.
- tc is high in the same cycle q first shows 0.
- zero is combinational from q, so it has no extra latency.
- A reset mid-count takes effect at the next edge and overrides both load and en.
- A load arriving in the tc cycle restarts the count on that edge.

## Configuration
- BCD_DOWN_AUTORELOAD_EN, when defined:
  - An enabled cycle with q == 0 and a stored preset != 0 reloads q from the stored preset and sets busy=1. tc still pulses when q reaches 0.
  - The result is a periodic divider with period (preset+1) enabled clocks.
  - If the stored preset is 0, q holds at 0 as in the non-autoreload case.
- When not defined, the counter is one-shot: it stops at 0 until the next load.

## Structure
- Package bcd_pkg holds:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_ZERO = 4'd0
  - the sanitize function that clamps a decade to 9 and flags it
- Sub-module bcd_digit_down is a single decade with:
  - inputs clk, rst_n, load, d, borrow_in
  - outputs q, borrow_out (high when borrow_in is high and q == 0)
- The top instantiates DIGITS copies in a borrow chain and adds the tc, busy, bad_bcd and preset registers.

## Test plan
- Reset: hold rst_n low for 2 edges while load=1 and din=0x42 → q=0x00, zero=1, tc=0, busy=0.
- Full countdown: load 0x19, then en=1 → q steps 0x18, 0x17 … 0x10, 0x09 … 0x00. tc=1 only on the 19th edge after the load, busy falls with it, and q stays 0x00 afterwards (default build).
- Borrow and clamp:
  - load 0x10 with en=1 → next value 0x09.
  - load 0x3A → q=0x39 and bad_bcd=1 for one cycle.
- Priority: load=1 with en=1 and din=0x05 → q=0x05, not 0x04. Toggling en low for 3 cycles mid-count freezes q.
- Reset mid-count: at q=0x07, pull rst_n low for one edge → q=0x00 and tc=0 with no pulse; counting does not resume.
- Autoreload build: load 0x03 with en held high → q sequence 3, 2, 1, 0, 3, 2, 1, 0. tc pulses every 4th edge.
